// File: rtl/rgp16_pkg.sv
// Shared types and defaults for the single-port memory arbiter.
package rgp16_pkg;

   localparam int unsigned STARVE_LIMIT_DEF = 4;
   localparam int unsigned AW_DEF           = 16;
   localparam int unsigned DW_DEF           = 16;
   localparam int unsigned STARVE_W         = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_IF   = 2'b01,
      OWN_DM   = 2'b10
   } owner_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive cycles fetch lost to data; raises force_if at the limit.
module arb_starve_cnt
   import rgp16_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic if_req,
   input  logic if_gnt,
   input  logic dm_gnt,
   output logic force_if
);

   logic [STARVE_W-1:0] cnt;
   logic [STARVE_W-1:0] cnt_nxt;

   always_comb begin
      cnt_nxt = cnt;
      if (!if_req || if_gnt) begin
         cnt_nxt = '0;
      end else if (dm_gnt && (cnt != STARVE_W'(STARVE_LIMIT))) begin
         cnt_nxt = cnt + STARVE_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
      end
   end

   assign force_if = if_req & (cnt == STARVE_W'(STARVE_LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read RAM port between fetch and data access; data wins
// unless fetch has starved, and responses are steered to the owner one cycle later.
module mem_port_arbiter
   import rgp16_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
   parameter int unsigned AW           = AW_DEF,
   parameter int unsigned DW           = DW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   input  logic          if_flush,
   output logic          if_gnt,
   output logic [DW-1:0] if_rdata,
   output logic          if_valid,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_gnt,
   output logic [DW-1:0] dm_rdata,
   output logic          dm_valid,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   output logic          ram_we,
   input  logic [DW-1:0] ram_rdata
);

   owner_e        owner;
   owner_e        owner_nxt;
   logic [AW-1:0] addr_q;
   logic          force_if;

   arb_starve_cnt #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_starve (
      .clk     (clk),
      .reset   (reset),
      .if_req  (if_req),
      .if_gnt  (if_gnt),
      .dm_gnt  (dm_gnt),
      .force_if(force_if)
   );

   // Owner of the access in flight, plus the held RAM address for idle cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner  <= OWN_NONE;
         addr_q <= '0;
      end else begin
         owner  <= owner_nxt;
         addr_q <= ram_addr;
      end
   end

   always_comb begin
      if_gnt    = 1'b0;
      dm_gnt    = 1'b0;
      owner_nxt = OWN_NONE;
      ram_addr  = addr_q;

      if (!reset) begin
         if (dm_req && !force_if) begin
            dm_gnt = 1'b1;
         end else if (if_req) begin
            if_gnt = 1'b1;
         end
      end

      // A fetch granted in a flush cycle still uses the port but returns nothing.
      if (dm_gnt) begin
         owner_nxt = OWN_DM;
         ram_addr  = dm_addr;
      end else if (if_gnt) begin
         ram_addr = if_addr;
         if (!if_flush) begin
            owner_nxt = OWN_IF;
         end
      end

      if (reset) begin
         ram_addr = '0;
      end

      ram_we   = dm_gnt & dm_we;
      if_valid = (owner == OWN_IF) & ~if_flush;
      dm_valid = (owner == OWN_DM);
   end

   assign ram_wdata = dm_wdata;
   assign if_rdata  = ram_rdata;
   assign dm_rdata  = ram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus random bench for mem_port_arbiter against a cycle-level reference model.
module tb_mem_port_arbiter;

   localparam int unsigned LIM = 4;
   localparam int unsigned AW  = 16;
   localparam int unsigned DW  = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_flush;
   logic          if_gnt;
   logic [DW-1:0] if_rdata;
   logic          if_valid;
   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          dm_gnt;
   logic [DW-1:0] dm_rdata;
   logic          dm_valid;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic          ram_we;
   logic [DW-1:0] ram_rdata;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.STARVE_LIMIT(LIM), .AW(AW), .DW(DW)) dut (
      .clk      (clk),
      .reset    (reset),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_flush (if_flush),
      .if_gnt   (if_gnt),
      .if_rdata (if_rdata),
      .if_valid (if_valid),
      .dm_req   (dm_req),
      .dm_we    (dm_we),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_gnt   (dm_gnt),
      .dm_rdata (dm_rdata),
      .dm_valid (dm_valid),
      .ram_addr (ram_addr),
      .ram_wdata(ram_wdata),
      .ram_we   (ram_we),
      .ram_rdata(ram_rdata)
   );

   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      if (a == 16'h0010) return 16'hABCD;
      return 16'((32'(a) * 32'h9E37) + 32'h1357);
   endfunction

   // RAM with registered read; read returns the contents before a same-edge write.
   logic [DW-1:0] ram_mem [int];
   always @(posedge clk) begin
      ram_rdata <= ram_mem.exists(int'(ram_addr)) ? ram_mem[int'(ram_addr)] : init_val(ram_addr);
      if (ram_we) ram_mem[int'(ram_addr)] = ram_wdata;
   end

   // Reference model state
   logic [DW-1:0] mdl_mem [int];
   int            m_pend   = 0;   // 0 none, 1 fetch, 2 data
   logic          m_load   = 1'b0;
   logic [DW-1:0] m_data   = '0;
   int            m_starve = 0;
   logic [AW-1:0] m_last   = '0;
   logic          g_if     = 1'b0;
   logic          g_dm     = 1'b0;

   logic          seen_if_gnt, seen_dm_gnt, seen_if_valid, seen_dm_valid, seen_ram_we;
   logic [DW-1:0] seen_if_rdata, seen_dm_rdata;
   logic [AW-1:0] seen_ram_addr;

   function automatic logic [DW-1:0] mdl_rd(input logic [AW-1:0] a);
      return mdl_mem.exists(int'(a)) ? mdl_mem[int'(a)] : init_val(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: check outputs against the model mid-cycle, then advance model and clock.
   task automatic step();
      logic          frc, exp_if, exp_dm;
      logic [AW-1:0] exp_addr;
      #2;
      seen_if_gnt   = if_gnt;
      seen_dm_gnt   = dm_gnt;
      seen_if_valid = if_valid;
      seen_dm_valid = dm_valid;
      seen_ram_we   = ram_we;
      seen_if_rdata = if_rdata;
      seen_dm_rdata = dm_rdata;
      seen_ram_addr = ram_addr;
      if (reset) begin
         exp_if   = 1'b0;
         exp_dm   = 1'b0;
         exp_addr = '0;
      end else begin
         frc      = if_req && (m_starve == int'(LIM));
         exp_dm   = dm_req && !frc;
         exp_if   = if_req && !exp_dm;
         exp_addr = exp_dm ? dm_addr : (exp_if ? if_addr : m_last);
         chk("if_valid", 32'(if_valid), 32'((m_pend == 1) && !if_flush));
         chk("dm_valid", 32'(dm_valid), 32'(m_pend == 2));
         if (m_pend == 1 && !if_flush) chk("if_rdata", 32'(if_rdata), 32'(m_data));
         if (m_pend == 2 && m_load) chk("dm_rdata", 32'(dm_rdata), 32'(m_data));
      end
      chk("if_gnt", 32'(if_gnt), 32'(exp_if));
      chk("dm_gnt", 32'(dm_gnt), 32'(exp_dm));
      chk("ram_we", 32'(ram_we), 32'(exp_dm && dm_we));
      chk("ram_addr", 32'(ram_addr), 32'(exp_addr));
      if (exp_dm && dm_we) chk("ram_wdata", 32'(ram_wdata), 32'(dm_wdata));
      g_if = exp_if;
      g_dm = exp_dm;
      if (reset) begin
         m_pend   = 0;
         m_starve = 0;
         m_last   = '0;
      end else begin
         if (exp_dm) begin
            m_pend = 2;
            m_load = !dm_we;
            m_data = mdl_rd(dm_addr);
            if (dm_we) mdl_mem[int'(dm_addr)] = dm_wdata;
         end else if (exp_if && !if_flush) begin
            m_pend = 1;
            m_data = mdl_rd(if_addr);
         end else begin
            m_pend = 0;
         end
         if (!if_req || exp_if) m_starve = 0;
         else if (exp_dm && m_starve < int'(LIM)) m_starve++;
         m_last = exp_addr;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_if(input logic req, input logic [AW-1:0] a, input logic fl);
      if_req   = req;
      if_addr  = a;
      if_flush = fl;
   endtask

   task automatic set_dm(input logic req, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd);
      dm_req   = req;
      dm_we    = we;
      dm_addr  = a;
      dm_wdata = wd;
   endtask

   initial begin
      logic [9:0] pat;
      reset = 1'b1;
      set_if(1'b1, 16'h0003, 1'b0);
      set_dm(1'b1, 1'b1, 16'h0005, 16'h7777);
      @(posedge clk);
      #1;
      step();
      step();
      reset = 1'b0;
      set_if(1'b0, 16'h0000, 1'b0);
      set_dm(1'b0, 1'b0, 16'h0000, 16'h0000);
      step();

      // Idle fetch
      set_if(1'b1, 16'h0010, 1'b0);
      step();
      chk("t1_if_gnt", 32'(seen_if_gnt), 32'd1);
      set_if(1'b0, 16'h0010, 1'b0);
      step();
      chk("t1_if_valid", 32'(seen_if_valid), 32'd1);
      chk("t1_if_rdata", 32'(seen_if_rdata), 32'hABCD);
      chk("t1_dm_valid", 32'(seen_dm_valid), 32'd0);

      // Collision
      set_if(1'b1, 16'h0020, 1'b0);
      set_dm(1'b1, 1'b0, 16'h0040, 16'h0000);
      step();
      chk("t2_dm_gnt", 32'(seen_dm_gnt), 32'd1);
      chk("t2_if_gnt", 32'(seen_if_gnt), 32'd0);
      chk("t2_ram_addr", 32'(seen_ram_addr), 32'h0040);
      set_dm(1'b0, 1'b0, 16'h0040, 16'h0000);
      step();
      chk("t2_dm_valid", 32'(seen_dm_valid), 32'd1);
      chk("t2_if_gnt_after", 32'(seen_if_gnt), 32'd1);
      set_if(1'b0, 16'h0020, 1'b0);
      step();

      // Starvation guard
      pat = '0;
      for (int k = 0; k < 10; k++) begin
         set_if(1'b1, 16'h0030, 1'b0);
         set_dm(1'b1, 1'b0, 16'(16'h0100 + k), 16'h0000);
         step();
         pat[k] = seen_if_gnt;
      end
      chk("t3_pattern", 32'(pat), 32'h0000_0210);
      set_if(1'b0, 16'h0030, 1'b0);
      set_dm(1'b0, 1'b0, 16'h0000, 16'h0000);
      step();

      // Store then load
      set_dm(1'b1, 1'b1, 16'h0080, 16'h1234);
      step();
      chk("t4_we_store", 32'(seen_ram_we), 32'd1);
      set_dm(1'b1, 1'b0, 16'h0080, 16'h0000);
      step();
      chk("t4_we_load", 32'(seen_ram_we), 32'd0);
      chk("t4_valid_store", 32'(seen_dm_valid), 32'd1);
      set_dm(1'b0, 1'b0, 16'h0000, 16'h0000);
      step();
      chk("t4_valid_load", 32'(seen_dm_valid), 32'd1);
      chk("t4_load_data", 32'(seen_dm_rdata), 32'h1234);

      // Flush A: kill returning word
      set_if(1'b1, 16'h0010, 1'b0);
      step();
      set_if(1'b0, 16'h0010, 1'b1);
      step();
      chk("t5a_if_valid", 32'(seen_if_valid), 32'd0);
      // Flush B: kill fetch granted in flush cycle
      set_if(1'b1, 16'h0011, 1'b1);
      step();
      chk("t5b_if_gnt", 32'(seen_if_gnt), 32'd1);
      set_if(1'b0, 16'h0011, 1'b0);
      step();
      chk("t5b_if_valid", 32'(seen_if_valid), 32'd0);
      // Flush C: load in flight unaffected
      set_dm(1'b1, 1'b0, 16'h0080, 16'h0000);
      step();
      set_dm(1'b0, 1'b0, 16'h0000, 16'h0000);
      set_if(1'b0, 16'h0000, 1'b1);
      step();
      chk("t5c_dm_valid", 32'(seen_dm_valid), 32'd1);
      chk("t5c_dm_rdata", 32'(seen_dm_rdata), 32'h1234);
      if_flush = 1'b0;

      // Reset mid-operation
      set_dm(1'b1, 1'b0, 16'h0040, 16'h0000);
      step();
      reset = 1'b1;
      set_if(1'b1, 16'h0050, 1'b0);
      set_dm(1'b1, 1'b1, 16'h0060, 16'hBEEF);
      step();
      chk("t6_rst_dm_gnt", 32'(seen_dm_gnt), 32'd0);
      chk("t6_rst_if_gnt", 32'(seen_if_gnt), 32'd0);
      chk("t6_rst_ram_we", 32'(seen_ram_we), 32'd0);
      chk("t6_rst_ram_addr", 32'(seen_ram_addr), 32'd0);
      reset = 1'b0;
      set_dm(1'b1, 1'b0, 16'h0060, 16'h0000);
      pat = '0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (k == 0) begin
            chk("t6_if_valid", 32'(seen_if_valid), 32'd0);
            chk("t6_dm_valid", 32'(seen_dm_valid), 32'd0);
         end
         pat[k] = seen_if_gnt;
      end
      chk("t6_starve_restart", 32'(pat), 32'h0000_0010);

      // Random traffic honouring the hold-until-grant protocol
      g_if = 1'b1;
      g_dm = 1'b1;
      for (int n = 0; n < 400; n++) begin
         if (!if_req || g_if) begin
            if_req  = ($urandom_range(0, 3) != 0);
            if_addr = 16'($urandom_range(0, 63));
         end
         if (!dm_req || g_dm) begin
            dm_req   = ($urandom_range(0, 2) != 0);
            dm_we    = 1'($urandom_range(0, 1));
            dm_addr  = 16'($urandom_range(0, 63));
            dm_wdata = 16'($urandom);
         end
         if_flush = ($urandom_range(0, 7) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
